uart_line_rx: RTL and testbench

Synthesizable, parametrised UART receiver with an integrated line-aware receive FIFO. It is the hardware successor to the bench UART monitor.
- Adds configurable data bits, parity, stop bits and 16x oversampling.
- Adds false-start rejection and framing/parity error detection.
- Each stored byte carries a "last" flag set when it equals a terminator character, so downstream logic can consume whole lines.
- Sits between the board RX pin and the on-chip command/display logic.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_fifo.sv | 44 ++++
 rtl/uart_line_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_line_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helpers for the line-aware UART receiver.
package uart_pkg;

    localparam int OVS = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * OVS);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO holding received bytes plus their last flag.
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_en,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en && !full)
                wptr <= wptr + 1'b1;
            if (rd_en && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_line_rx.sv
// UART receiver with 16x oversampling, error detection and a line-aware receive FIFO.
module uart_line_rx
    import uart_pkg::*;
#(
    parameter int         CLK_HZ     = 100000000,
    parameter int         BAUD       = 115200,
    parameter int         DATA_BITS  = 8,
    parameter int         PARITY     = 0,
    parameter int         STOP_BITS  = 1,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 line_avail,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overflow
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int PW  = $clog2(DIV + 1);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_BITS-1:0] TERM = TERM_CHAR[DATA_BITS-1:0];

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic [PW-1:0]        presc;
    logic                 tick;
    rx_state_t            state;
    logic [3:0]           tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 bad;
    logic                 start_edge;
    logic                 mid_tick;
    logic                 bit_tick;
    logic                 last_stop;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DATA_BITS:0]   head;
    logic [LW-1:0]        line_cnt;

    // Synchronizer resets high so leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == ST_IDLE) && rx_prev && !rx_sync;
    assign tick       = (presc == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || start_edge)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    assign mid_tick  = tick && (tick_cnt == 4'd7);
    assign bit_tick  = tick && (tick_cnt == 4'd15);
    assign last_stop = (bit_cnt == 3'(STOP_BITS - 1));
    assign push      = (state == ST_STOP) && bit_tick && rx_sync &&
                       last_stop && !bad && !full;
    assign pop       = !empty && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            bad          <= 1'b0;
            err_frame    <= 1'b0;
            err_parity   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_frame    <= 1'b0;
            err_parity   <= 1'b0;
            err_overflow <= 1'b0;
            if (tick)
                tick_cnt <= tick_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    bad      <= 1'b0;
                    if (start_edge)
                        state <= ST_START;
                end
                ST_START: begin
                    // Re-centre the tick counter on the middle of the start bit.
                    if (mid_tick) begin
                        tick_cnt <= '0;
                        state    <= rx_sync ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        bad   <= ((^shreg) ^ rx_sync) != (PARITY == PAR_ODD);
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (!rx_sync) begin
                            err_frame <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end else if (last_stop) begin
                            if (bad)
                                err_parity <= 1'b1;
                            else if (full)
                                err_overflow <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_sync)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH(DATA_BITS + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_data({shreg == TERM, shreg}),
        .wr_en  (push),
        .full   (full),
        .rd_data(head),
        .rd_en  (pop),
        .empty  (empty)
    );

    logic push_last;
    logic pop_last;

    assign push_last = push && (shreg == TERM);
    assign pop_last  = pop && head[DATA_BITS];

    always_ff @(posedge clk) begin
        if (rst)
            line_cnt <= '0;
        else if (push_last && !pop_last)
            line_cnt <= line_cnt + 1'b1;
        else if (pop_last && !push_last)
            line_cnt <= line_cnt - 1'b1;
    end

    assign m_valid    = !empty;
    assign m_data     = m_valid ? head[DATA_BITS-1:0] : '0;
    assign m_last     = m_valid && head[DATA_BITS];
    assign line_avail = (line_cnt != '0);

endmodule

// File: tb/tb_uart_line_rx.sv
// Scoreboard bench for uart_line_rx: one default-rate instance and two fast instances.
module tb_uart_line_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst          [3];
    logic       rx           [3];
    logic       m_ready      [3];
    logic [7:0] m_data       [3];
    logic       m_last       [3];
    logic       m_valid      [3];
    logic       line_avail   [3];
    logic       err_frame    [3];
    logic       err_parity   [3];
    logic       err_overflow [3];

    // Channel 0 uses the default rate; 1 and 2 run at 64 clocks per bit.
    int         bit_clk [3] = '{864, 64, 64};
    logic [8:0] exp_q   [3][$];
    int         n_fe    [3] = '{0, 0, 0};
    int         n_pe    [3] = '{0, 0, 0};
    int         n_oe    [3] = '{0, 0, 0};
    int         base_fe, base_pe, base_oe;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] t1_bytes [3] = '{8'h41, 8'h42, 8'h0D};

    uart_line_rx u_def (
        .clk(clk), .rst(rst[0]), .rx(rx[0]),
        .m_data(m_data[0]), .m_last(m_last[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .line_avail(line_avail[0]),
        .err_frame(err_frame[0]), .err_parity(err_parity[0]),
        .err_overflow(err_overflow[0])
    );

    uart_line_rx #(.CLK_HZ(7372800)) u_fast (
        .clk(clk), .rst(rst[1]), .rx(rx[1]),
        .m_data(m_data[1]), .m_last(m_last[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .line_avail(line_avail[1]),
        .err_frame(err_frame[1]), .err_parity(err_parity[1]),
        .err_overflow(err_overflow[1])
    );

    uart_line_rx #(.CLK_HZ(7372800), .PARITY(2)) u_par (
        .clk(clk), .rst(rst[2]), .rx(rx[2]),
        .m_data(m_data[2]), .m_last(m_last[2]), .m_valid(m_valid[2]),
        .m_ready(m_ready[2]), .line_avail(line_avail[2]),
        .err_frame(err_frame[2]), .err_parity(err_parity[2]),
        .err_overflow(err_overflow[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (err_frame[k])    n_fe[k]++;
            if (err_parity[k])   n_pe[k]++;
            if (err_overflow[k]) n_oe[k]++;
            if (m_valid[k] && m_ready[k] && !rst[k]) begin
                check($sformatf("pop_pending%0d", k), exp_q[k].size() != 0, 1);
                if (exp_q[k].size() != 0)
                    check($sformatf("pop_data%0d", k),
                          {m_last[k], m_data[k]}, exp_q[k].pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int ch, input logic v);
        rx[ch] = v;
        step(bit_clk[ch]);
    endtask

    // par: 0 none, 1 correct even parity, 2 wrong even parity
    task automatic send(input int ch, input logic [7:0] d, input int par,
                        input logic stop);
        drive_bit(ch, 1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(ch, d[i]);
        if (par != 0)
            drive_bit(ch, (^d) ^ (par == 2));
        drive_bit(ch, stop);
        drive_bit(ch, 1'b1);
    endtask

    task automatic mark(input int ch);
        base_fe = n_fe[ch];
        base_pe = n_pe[ch];
        base_oe = n_oe[ch];
    endtask

    task automatic check_errs(input string tag, input int ch, input int fe,
                              input int pe, input int oe);
        check({tag, "_frame"},    n_fe[ch] - base_fe, fe);
        check({tag, "_parity"},   n_pe[ch] - base_pe, pe);
        check({tag, "_overflow"}, n_oe[ch] - base_oe, oe);
    endtask

    task automatic check_idle_out(input string tag, input int ch);
        check(tag, {m_valid[ch], m_last[ch], line_avail[ch], err_frame[ch],
                    err_parity[ch], err_overflow[ch], m_data[ch]}, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]     = 1'b1;
            rx[k]      = 1'b1;
            m_ready[k] = 1'b0;
        end
        step(5);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check_idle_out($sformatf("reset_out%0d", k), k);
        step(1);
        for (int k = 0; k < 3; k++)
            rst[k] = 1'b0;
        step(5);

        // Line assembly with consumer stalled, then drained.
        mark(0);
        foreach (t1_bytes[i]) begin
            exp_q[0].push_back({t1_bytes[i] == 8'h0D, t1_bytes[i]});
            send(0, t1_bytes[i], 0, 1'b1);
        end
        @(negedge clk);
        check("t1_head", {m_valid[0], m_last[0], m_data[0]}, {2'b10, 8'h41});
        check("t1_line", line_avail[0], 1);
        step(1);
        m_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_valid", m_valid[0], 1);
            check("t1_line_held", line_avail[0], 1);
        end
        @(negedge clk);
        check_idle_out("t1_drained", 0);
        check("t1_q", exp_q[0].size(), 0);
        check_errs("t1", 0, 0, 0, 0);

        // Short low glitch is a false start.
        step(1);
        mark(0);
        rx[0] = 1'b0;
        step(300);
        rx[0] = 1'b1;
        step(2000);
        check("t2_valid", m_valid[0], 0);
        check_errs("t2", 0, 0, 0, 0);

        // Framing error, then recovery.
        m_ready[1] = 1'b1;
        mark(1);
        send(1, 8'h55, 0, 1'b0);
        check_errs("t3a", 1, 1, 0, 0);
        check("t3_valid", m_valid[1], 0);
        exp_q[1].push_back({1'b1, 8'h0D});
        send(1, 8'h0D, 0, 1'b1);
        step(10);
        check("t3_q", exp_q[1].size(), 0);
        check_errs("t3b", 1, 1, 0, 0);

        // Even parity: bad parity dropped, good parity stored.
        m_ready[2] = 1'b1;
        mark(2);
        send(2, 8'h07, 2, 1'b1);
        check_errs("t4a", 2, 0, 1, 0);
        check("t4_valid", m_valid[2], 0);
        exp_q[2].push_back({1'b0, 8'h07});
        send(2, 8'h07, 1, 1'b1);
        step(10);
        check("t4_q", exp_q[2].size(), 0);
        check_errs("t4b", 2, 0, 1, 0);

        // Overflow on the seventeenth byte.
        m_ready[1] = 1'b0;
        mark(1);
        for (int i = 0; i < 17; i++) begin
            if (i < 16)
                exp_q[1].push_back({1'b0, 8'h30});
            send(1, 8'h30, 0, 1'b1);
        end
        @(negedge clk);
        check_errs("t5", 1, 0, 0, 1);
        check("t5_head", {m_valid[1], m_last[1], line_avail[1], m_data[1]},
              {3'b100, 8'h30});
        step(1);
        m_ready[1] = 1'b1;
        step(20);
        check("t5_q", exp_q[1].size(), 0);
        check("t5_valid", m_valid[1], 0);

        // Reset in the middle of a frame with a byte already queued.
        m_ready[1] = 1'b0;
        exp_q[1].push_back({1'b0, 8'h31});
        send(1, 8'h31, 0, 1'b1);
        check("t6_pre", m_valid[1], 1);
        mark(1);
        drive_bit(1, 1'b0);
        for (int i = 0; i < 7; i++)
            drive_bit(1, (i == 0 || i == 2 || i == 5));
        rx[1] = 1'b1;
        step(bit_clk[1] / 2);
        rst[1] = 1'b1;
        step(1);
        rst[1] = 1'b0;
        exp_q[1].delete();
        @(negedge clk);
        check_idle_out("t6_reset_out", 1);
        step(bit_clk[1] / 2);
        drive_bit(1, 1'b1);
        drive_bit(1, 1'b1);
        check("t6_valid", m_valid[1], 0);
        check_errs("t6a", 1, 0, 0, 0);
        m_ready[1] = 1'b1;
        exp_q[1].push_back({1'b0, 8'h5A});
        send(1, 8'h5A, 0, 1'b1);
        step(10);
        check("t6_q", exp_q[1].size(), 0);
        check_errs("t6b", 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
